hazard_fwd_unit: RTL
====================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard and forwarding controller for the ID stage of the pipelined MIPS core.
//  Tracks destination registers of in-flight instructions across FWD_STAGES downstream stages.
//  Selects register-file or forwarded data for rs/rt, and raises a stall on load-use hazards,
//  covering any load latency. Replaces the fixed EX/MEM forwarding muxes and the single-cycle
//  load stall.
// PARAMETERS
//  DATA_W      32  datapath width
//  ADDR_W      5   register address width; register 0 is hardwired zero
//  FWD_STAGES  3   tracked stages after ID (index 0 = EX, 1 = MEM, 2 = WB)
//  LOAD_LAT    1   load data is valid only at tracked stage index >= LOAD_LAT
//  CNT_W       16  stall counter width
//  SEL_W       derived: clog2(FWD_STAGES+1)
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  synchronous reset, active-high
//  id_valid_i    in   1                  ID holds a real instruction
//  id_rs_en_i    in   1                  rs operand is read
//  id_rs_addr_i  in   ADDR_W             rs address
//  id_rt_en_i    in   1                  rt operand is read
//  id_rt_addr_i  in   ADDR_W             rt address
//  id_wr_en_i    in   1                  ID instruction writes a register
//  id_wr_addr_i  in   ADDR_W             destination address
//  id_is_load_i  in   1                  ID instruction is a load
//  flush_i       in   1                  squash the ID instruction (taken branch / redirect)
//  rf_rs_data_i  in   DATA_W             register-file rs data
//  rf_rt_data_i  in   DATA_W             register-file rt data
//  stage_data_i  in   FWD_STAGES*DATA_W  result of stage k at bits [k*DATA_W +: DATA_W]
//  rs_data_o     out  DATA_W             resolved rs operand
//  rt_data_o     out  DATA_W             resolved rt operand
//  rs_sel_o      out  SEL_W              0 = regfile, k+1 = stage k
//  rt_sel_o      out  SEL_W              same encoding as rs_sel_o
//  stall_o       out  1                  freeze PC and IF/ID; inject bubble into EX
//  stall_cnt_o   out  CNT_W              saturating count of stall cycles
// BEHAVIOUR
//  State: tracker entries trk[k] = {valid, addr, is_load} for k = 0..FWD_STAGES-1, plus stall_cnt.
//  Reset: all trk valid = 0 and stall_cnt = 0.
//    After reset: stall_o = 0, sel = 0, data = rf data.
//  Operand match (per operand): en & addr != 0 & trk[k].valid & trk[k].addr == addr.
//    The lowest matching k (youngest writer) wins. Older matches are ignored.
//  No match, en = 0, or addr = 0: sel = 0 and data = rf data.
//    A read of address 0 always returns rf data (zero).
//  Winning k with is_load & k < LOAD_LAT: hazard for that operand.
//    Otherwise sel = k+1 and data = stage_data_i slice k.
//  Combinational path: stall_o = id_valid_i & ~flush_i & (rs hazard | rt hazard).
//    sel and data are combinational from state and inputs, zero-cycle latency.
//    On a hazard, sel/data still show the winner (don't-care while stalled).
//  Each clk edge when rst = 0, the tracker shifts:
//    trk[k] <= trk[k-1] for k >= 1.
//    trk[0] <= {1, id_wr_addr_i, id_is_load_i} iff
//      id_valid_i & id_wr_en_i & id_wr_addr_i != 0 & ~stall_o & ~flush_i.
//    Otherwise trk[0] <= bubble (valid = 0).
//  Stall and flush in the same cycle: flush wins; stall_o = 0 and a bubble enters.
//  Stalled instruction is re-presented by ID next cycle.
//    The load advances one stage per cycle, so the stall lasts exactly LOAD_LAT - k cycles.
//  stall_cnt: +1 on each cycle with stall_o = 1; holds at 2^CNT_W - 1.
//  rst asserted mid-stall: next edge clears tracker and counter; stall_o drops with rst.
//  LOAD_LAT = 0: loads never stall (pure forwarding).
//  LOAD_LAT >= FWD_STAGES: a load writer always stalls until it leaves the tracker.
// TESTING
//  1. rst = 1 for 2 cycles with random inputs -> stall_o = 0, rs_sel_o = rt_sel_o = 0,
//     stall_cnt_o = 0, rs_data_o = rf_rs_data_i.
//  2. Issue addu $3; next cycle rs = $3, stage_data[0] = 0x00001234
//     -> rs_sel_o = 1, rs_data_o = 0x00001234, stall_o = 0.
//  3. LOAD_LAT = 1: issue lw $5; next cycle rt = $5 -> stall_o = 1 for exactly 1 cycle;
//     then rt_sel_o = 2, rt_data_o = stage_data[1]; stall_cnt_o = 1.
//  4. Writes to $7 at EX and MEM, read rs = $7 -> rs_sel_o = 1 (youngest);
//     read rs = $0 after write to $0 -> rs_sel_o = 0, rs_data_o = 0.
//  5. Issue lw $9 with flush_i = 1; next cycle read $9 -> no match, rs_sel_o = 0, stall_o = 0.
//  6. Load-use stall in progress, assert rst one cycle -> stall_o = 0 that cycle;
//     after release tracker empty, stall_cnt_o = 0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the ID stage: tracks in-flight destination
// registers, resolves rs/rt operands to regfile or stage data, and stalls on load-use.
module hazard_fwd_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FWD_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid_i,
  input  logic                       id_rs_en_i,
  input  logic [ADDR_W-1:0]          id_rs_addr_i,
  input  logic                       id_rt_en_i,
  input  logic [ADDR_W-1:0]          id_rt_addr_i,
  input  logic                       id_wr_en_i,
  input  logic [ADDR_W-1:0]          id_wr_addr_i,
  input  logic                       id_is_load_i,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          rf_rs_data_i,
  input  logic [DATA_W-1:0]          rf_rt_data_i,
  input  logic [FWD_STAGES*DATA_W-1:0] stage_data_i,
  output logic [DATA_W-1:0]          rs_data_o,
  output logic [DATA_W-1:0]          rt_data_o,
  output logic [SEL_W-1:0]           rs_sel_o,
  output logic [SEL_W-1:0]           rt_sel_o,
  output logic                       stall_o,
  output logic [CNT_W-1:0]           stall_cnt_o
);

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
    logic              haz;
  } res_t;

  logic [FWD_STAGES-1:0] trk_vld_q, trk_vld_d;
  logic [FWD_STAGES-1:0] trk_load_q, trk_load_d;
  logic [ADDR_W-1:0]     trk_addr_q [FWD_STAGES];
  logic [ADDR_W-1:0]     trk_addr_d [FWD_STAGES];
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  res_t rs_res, rt_res;
  logic push;

  // Walk from the oldest stage to the youngest so the youngest match overwrites.
  function automatic res_t resolve(input logic en,
                                   input logic [ADDR_W-1:0] addr,
                                   input logic [DATA_W-1:0] rf);
    res_t r;
    r.sel  = '0;
    r.data = rf;
    r.haz  = 1'b0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (en && (addr != '0) && trk_vld_q[k] && (trk_addr_q[k] == addr)) begin
        r.sel  = SEL_W'(k + 1);
        r.data = stage_data_i[k*DATA_W +: DATA_W];
        r.haz  = trk_load_q[k] && (k < LOAD_LAT);
      end
    end
    return r;
  endfunction

  always_comb begin
    rs_res = resolve(id_rs_en_i & ~rst, id_rs_addr_i, rf_rs_data_i);
    rt_res = resolve(id_rt_en_i & ~rst, id_rt_addr_i, rf_rt_data_i);
  end

  assign rs_sel_o  = rs_res.sel;
  assign rs_data_o = rs_res.data;
  assign rt_sel_o  = rt_res.sel;
  assign rt_data_o = rt_res.data;

  // Flush squashes the instruction, so it can never be the one that stalls.
  assign stall_o = ~rst & id_valid_i & ~flush_i & (rs_res.haz | rt_res.haz);

  assign push = id_valid_i & id_wr_en_i & (id_wr_addr_i != '0) & ~stall_o & ~flush_i;

  always_comb begin
    trk_vld_d  = '0;
    trk_load_d = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      trk_addr_d[k] = '0;
    end
    trk_vld_d[0]  = push;
    trk_load_d[0] = id_is_load_i;
    trk_addr_d[0] = id_wr_addr_i;
    for (int k = 1; k < FWD_STAGES; k++) begin
      trk_vld_d[k]  = trk_vld_q[k-1];
      trk_load_d[k] = trk_load_q[k-1];
      trk_addr_d[k] = trk_addr_q[k-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_vld_q   <= '0;
      trk_load_q  <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < FWD_STAGES; k++) begin
        trk_addr_q[k] <= '0;
      end
    end else begin
      trk_vld_q   <= trk_vld_d;
      trk_load_q  <= trk_load_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 0; k < FWD_STAGES; k++) begin
        trk_addr_q[k] <= trk_addr_d[k];
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
